// File: rtl/ramp_adc_pkg.sv
// Purpose: shared types and sizing helpers for the ramp-compare ADC capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ramp_adc_pkg;

    // Capture FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ARMED = 2'd2,
        DONE  = 2'd3
    } adc_state_e;

    // Accumulator width: holds 2^avg_log2 samples of width bits without overflow.
    function automatic int acc_width(input int width, input int avg_log2);
        return width + avg_log2;
    endfunction

    // Bits needed to hold 0..max_val, never less than 1.
    function automatic int cnt_width(input int max_val);
        return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ramp_adc_capture_sync.sv
// Purpose: multi-flop synchronizer bringing the asynchronous comparator into clk.
// Latency: SYNC_STAGES clocks from async_i to sync_o.
// Backpressure: none.
// Ports: clk, reset (sync, active-high), async_i (raw comparator), sync_o (synchronized).
module comp_synchronizer #(
    parameter int SYNC_STAGES = 2   // must be 2 or more
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ramp_adc_capture.sv
// Purpose: single-slope ADC capture; latches ramp_code at comparator trip, averages 2^AVG_LOG2 captures.
// Latency: adc_valid one clock after the final capture of a set (plus SYNC_STAGES on comp_in).
// Backpressure: none; adc_valid is a one-cycle pulse with no ready, results must be taken when offered.
// Ports: clk, reset (sync, active-high), enable, comp_in (async), ramp_code[WIDTH];
//        adc_code[WIDTH], adc_valid (pulse), over_range (any no-trip sweep in the set).
module ramp_adc_capture
    import ramp_adc_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int AVG_LOG2     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int BLANK_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             comp_in,
    input  logic [WIDTH-1:0] ramp_code,
    output logic [WIDTH-1:0] adc_code,
    output logic             adc_valid,
    output logic             over_range
);

    localparam int ACC_W = acc_width(WIDTH, AVG_LOG2);
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int BLK_W = cnt_width(BLANK_CYCLES);

    localparam logic [BLK_W-1:0] BLANK_LOAD   = BLK_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CAPTURE = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [WIDTH-1:0] FULL_SCALE   = '1;

    logic              comp_s;
    logic [WIDTH-1:0]  ramp_prev_q;
    logic              wrap;

    adc_state_e        state_q, state_d;
    logic [BLK_W-1:0]  blank_cnt_q, blank_cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;
    logic              sticky_q, sticky_d;
    logic [WIDTH-1:0]  adc_code_q, adc_code_d;
    logic              adc_valid_q, adc_valid_d;
    logic              over_range_q, over_range_d;

    logic              capture;
    logic [WIDTH-1:0]  cap_sample;
    logic              cap_ovr;

    comp_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (comp_in),
        .sync_o  (comp_s)
    );

    // Sweep boundary: sawtooth fell from a nonzero code back to 0.
    assign wrap = (ramp_prev_q != '0) && (ramp_code == '0);

    // Capture FSM. The comparator is only honoured in ARMED, so ringing right
    // after the ramp resets (and the synchronizer tail from the previous sweep)
    // is masked by BLANK.
    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        capture     = 1'b0;
        cap_sample  = '0;
        cap_ovr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ramp_code == '0) begin
                    state_d     = BLANK;
                    blank_cnt_d = BLANK_LOAD;
                end
            end
            BLANK: begin
                if (wrap) begin
                    blank_cnt_d = BLANK_LOAD;
                end else if (blank_cnt_q == '0) begin
                    state_d = ARMED;
                end else begin
                    blank_cnt_d = blank_cnt_q - BLK_W'(1);
                end
            end
            ARMED: begin
                // A wrap wins over a same-cycle trip: the ramp already reset,
                // so ramp_code no longer reflects the trip point.
                if (wrap) begin
                    capture     = 1'b1;
                    cap_sample  = FULL_SCALE;
                    cap_ovr     = 1'b1;
                    state_d     = BLANK;
                    blank_cnt_d = BLANK_LOAD;
                end else if (comp_s) begin
                    capture    = 1'b1;
                    cap_sample = ramp_code;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (wrap) begin
                    state_d     = BLANK;
                    blank_cnt_d = BLANK_LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!enable) begin
            state_d     = IDLE;
            blank_cnt_d = '0;
            capture     = 1'b0;
        end
    end

    // Averaging. The final capture of a set publishes straight from the
    // combinational sum so the result lands one clock after that capture.
    always_comb begin
        acc_sum      = acc_q + ACC_W'(cap_sample);
        acc_d        = acc_q;
        cap_cnt_d    = cap_cnt_q;
        sticky_d     = sticky_q;
        adc_code_d   = adc_code_q;
        over_range_d = over_range_q;
        adc_valid_d  = 1'b0;

        if (!enable) begin
            acc_d     = '0;
            cap_cnt_d = '0;
            sticky_d  = 1'b0;
        end else if (capture) begin
            if (cap_cnt_q == LAST_CAPTURE) begin
                adc_code_d   = WIDTH'(acc_sum >> AVG_LOG2);
                over_range_d = sticky_q | cap_ovr;
                adc_valid_d  = 1'b1;
                acc_d        = '0;
                cap_cnt_d    = '0;
                sticky_d     = 1'b0;
            end else begin
                acc_d     = acc_sum;
                cap_cnt_d = cap_cnt_q + CNT_W'(1);
                sticky_d  = sticky_q | cap_ovr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ramp_prev_q  <= '0;
            state_q      <= IDLE;
            blank_cnt_q  <= '0;
            acc_q        <= '0;
            cap_cnt_q    <= '0;
            sticky_q     <= 1'b0;
            adc_code_q   <= '0;
            adc_valid_q  <= 1'b0;
            over_range_q <= 1'b0;
        end else begin
            ramp_prev_q  <= ramp_code;
            state_q      <= state_d;
            blank_cnt_q  <= blank_cnt_d;
            acc_q        <= acc_d;
            cap_cnt_q    <= cap_cnt_d;
            sticky_q     <= sticky_d;
            adc_code_q   <= adc_code_d;
            adc_valid_q  <= adc_valid_d;
            over_range_q <= over_range_d;
        end
    end

    assign adc_code   = adc_code_q;
    assign adc_valid  = adc_valid_q;
    assign over_range = over_range_q;

endmodule

// File: tb/tb_ramp_adc_capture.sv
// Purpose: directed bench for ramp_adc_capture (WIDTH=8, AVG_LOG2=2, BLANK_CYCLES=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_ramp_adc_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       comp_in;
    logic [7:0] ramp_code;
    logic [7:0] adc_code;
    logic       adc_valid;
    logic       over_range;

    always #5 clk = ~clk;

    ramp_adc_capture #(
        .WIDTH        (8),
        .AVG_LOG2     (2),
        .SYNC_STAGES  (2),
        .BLANK_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .comp_in    (comp_in),
        .ramp_code  (ramp_code),
        .adc_code   (adc_code),
        .adc_valid  (adc_valid),
        .over_range (over_range)
    );

    // Per-sweep trip descriptor: -1 no trip, -2 toggles at 40/60/80,
    // 0 high for the whole sweep, otherwise rises at that ramp code.
    typedef struct packed {
        int t0;
        int t1;
        int t2;
        int t3;
        bit pulse;      // extra comp_in pulse in the first cycles of code 0
        int step;       // clocks per nonzero ramp code
        int exp_code;
        bit exp_ovr;
    } vec_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ovr;
    } res_t;

    vec_t vecs[7];
    res_t got[$];
    int   total = 0;
    int   bad   = 0;
    int   ncyc  = 0;
    int   rise_cyc = 0;
    int   valid_cyc = 0;
    int   gc;
    int   go;

    always @(posedge clk) ncyc <= ncyc + 1;

    always @(negedge clk) begin
        if (adc_valid === 1'b1) begin
            got.push_back({adc_code, over_range});
            valid_cyc = ncyc;
        end
    end

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input bit p, input int s, input int ec, input bit eo);
        vec_t v;
        v.t0 = a; v.t1 = b; v.t2 = c; v.t3 = d;
        v.pulse = p; v.step = s; v.exp_code = ec; v.exp_ovr = eo;
        return v;
    endfunction

    function automatic bit comp_for(input int trip, input int code);
        if (trip == -1) return 1'b0;
        if (trip == -2) return ((code >= 40) && (code < 60)) || (code >= 80);
        return code >= trip;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int code, input bit c);
        @(negedge clk);
        ramp_code = 8'(code);
        comp_in   = c;
    endtask

    // One sawtooth sweep: code 0 is always held 16 clocks so blanking and
    // synchronizer delay finish before the ramp leaves 0.
    task automatic sweep(input int trip, input bit pulse, input int step);
        bit v;
        bit prev;
        bit seen;
        int n;
        prev = comp_in;
        seen = 1'b0;
        for (int c = 0; c < 256; c++) begin
            n = (c == 0) ? 16 : step;
            for (int i = 0; i < n; i++) begin
                v = comp_for(trip, c);
                if (pulse && (c == 0) && (i < 2)) v = 1'b1;
                drive(c, v);
                if (v && !prev && (c > 0) && !seen) begin
                    rise_cyc = ncyc;
                    seen = 1'b1;
                end
                prev = v;
            end
        end
    endtask

    // Closing wrap (captures a trailing no-trip sweep), then disable to reset the set.
    task automatic tail();
        for (int i = 0; i < 16; i++) drive(0, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) drive(0, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        comp_in   = 1'b0;
        ramp_code = 8'd0;

        // Code 0 held 16 clocks everywhere; vec 0 uses the full 16-clock step,
        // the rest step every 4 clocks to keep the run short.
        vecs[0] = mk(100, 100, 100, 100, 1'b0, 16, 100, 1'b0);
        vecs[1] = mk(100, 101, 102, 103, 1'b0, 4, 101, 1'b0);
        vecs[2] = mk(-1, -1, -1, -1,     1'b0, 4, 255, 1'b1);
        vecs[3] = mk(50, 50, 50, -1,     1'b0, 4, 101, 1'b1);
        vecs[4] = mk(0, 0, 0, 0,         1'b0, 4, 0,   1'b0);
        vecs[5] = mk(100, 100, 100, 100, 1'b1, 4, 100, 1'b0);
        vecs[6] = mk(-2, -2, -2, -2,     1'b0, 4, 40,  1'b0);

        repeat (3) drive(0, 1'b0);
        check("reset adc_code", int'(adc_code), 0);
        check("reset adc_valid", int'(adc_valid), 0);
        check("reset over_range", int'(over_range), 0);
        reset = 1'b0;
        repeat (2) drive(0, 1'b0);

        for (int v = 0; v < 7; v++) begin
            got.delete();
            enable = 1'b1;
            sweep(vecs[v].t0, vecs[v].pulse, vecs[v].step);
            sweep(vecs[v].t1, vecs[v].pulse, vecs[v].step);
            sweep(vecs[v].t2, vecs[v].pulse, vecs[v].step);
            sweep(vecs[v].t3, vecs[v].pulse, vecs[v].step);
            tail();
            gc = (got.size() > 0) ? int'(got[0].code) : -1;
            go = (got.size() > 0) ? int'(got[0].ovr) : -1;
            check($sformatf("vec%0d valid count", v), got.size(), 1);
            check($sformatf("vec%0d adc_code", v), gc, vecs[v].exp_code);
            check($sformatf("vec%0d over_range", v), go, int'(vecs[v].exp_ovr));
            // Trip -> 2 sync flops -> capture edge -> valid register.
            if (vecs[v].t3 > 0)
                check($sformatf("vec%0d latency", v), valid_cyc - rise_cyc, 3);
        end

        // Reset after two captures discards them.
        got.delete();
        enable = 1'b1;
        sweep(200, 1'b0, 4);
        sweep(200, 1'b0, 4);
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) drive(0, 1'b0);
        reset = 1'b0;
        check("rst mid adc_code", int'(adc_code), 0);
        check("rst mid over_range", int'(over_range), 0);
        enable = 1'b1;
        sweep(60, 1'b0, 4);
        sweep(60, 1'b0, 4);
        sweep(60, 1'b0, 4);
        check("rst no early valid", got.size(), 0);
        check("rst code held", int'(adc_code), 0);
        sweep(60, 1'b0, 4);
        tail();
        gc = (got.size() > 0) ? int'(got[0].code) : -1;
        check("rst valid count", got.size(), 1);
        check("rst fresh adc_code", gc, 60);

        // Enable drop after two captures discards them, outputs hold.
        got.delete();
        enable = 1'b1;
        sweep(200, 1'b0, 4);
        sweep(200, 1'b0, 4);
        enable = 1'b0;
        repeat (4) drive(0, 1'b0);
        check("en off no valid", got.size(), 0);
        check("en off code held", int'(adc_code), 60);
        check("en off ovr held", int'(over_range), 0);
        enable = 1'b1;
        sweep(20, 1'b0, 4);
        sweep(20, 1'b0, 4);
        sweep(20, 1'b0, 4);
        check("en no early valid", got.size(), 0);
        check("en code held", int'(adc_code), 60);
        sweep(20, 1'b0, 4);
        tail();
        gc = (got.size() > 0) ? int'(got[0].code) : -1;
        check("en valid count", got.size(), 1);
        check("en fresh adc_code", gc, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
